// File: rtl/debug_port_pkg.sv
// debug_port_pkg: shared debug register map, opcode, mode and load-source constants.
package debug_port_pkg;

    localparam logic [2:0] DEBUG_ADDRX_OP     = 3'd0;
    localparam logic [2:0] DEBUG_ADDRX_MODE   = 3'd1;
    localparam logic [2:0] DEBUG_ADDRX_AL     = 3'd2;
    localparam logic [2:0] DEBUG_ADDRX_AH     = 3'd3;
    localparam logic [2:0] DEBUG_ADDRX_DL     = 3'd4;
    localparam logic [2:0] DEBUG_ADDRX_DH     = 3'd5;
    localparam logic [2:0] DEBUG_ADDRX_STATUS = 3'd6;
    localparam logic [2:0] DEBUG_ADDRX_RSVD   = 3'd7;

    localparam logic [3:0] DEBUG_OPX_NONE   = 4'd0;
    localparam logic [3:0] DEBUG_OPX_RD_MEM = 4'd1;
    localparam logic [3:0] DEBUG_OPX_WR_MEM = 4'd2;
    localparam logic [3:0] DEBUG_OPX_RD_REG = 4'd3;
    localparam logic [3:0] DEBUG_OPX_WR_REG = 4'd4;
    localparam logic [3:0] DEBUG_OPX_STEP   = 4'd5;

    localparam logic [7:0] DEBUG_MODEX_STOP = 8'h03;

    localparam logic [1:0] DEBUG_DATAX_DIN_DIN   = 2'd0;
    localparam logic [1:0] DEBUG_DATAX_REGB_DATA = 2'd1;
    localparam logic [1:0] DEBUG_DATAX_CC_DATA   = 2'd2;
    localparam logic [1:0] DEBUG_DATAX_PC_A_NEXT = 2'd3;

    typedef logic [15:0] dbg_word_t;

    function automatic logic [7:0] debug_status(input logic stop, input logic mode, input logic req);
        return {5'b0, stop, mode, req};
    endfunction

endpackage

// File: rtl/debug_strobe_sync.sv
// debug_strobe_sync: 2-flop synchronizer for an active-low host strobe with a one-cycle pulse on its rising edge.
module debug_strobe_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_strobe_n,
    output logic o_rise
);

    logic [1:0] r_sync;
    logic       r_prev;

    // Idle level is high so leaving reset never fakes a strobe end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_strobe_n};
            r_prev <= r_sync[1];
        end
    end

    assign o_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/debug_port.sv
// debug_port: host-side debug register file with REQ/ACK command handshake to the core.
module debug_port
    import debug_port_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_reset,
    input  logic [7:0]  i_debug_din,
    output logic [7:0]  o_debug_dout,
    input  logic [2:0]  i_debug_addr,
    input  logic        i_debug_rdn,
    input  logic        i_debug_wrn,
    output logic [3:0]  o_debug_op,
    output logic [3:0]  o_debug_argx_out,
    output logic [15:0] o_debug_addr_out,
    output logic [15:0] o_debug_data_out,
    input  logic        i_debug_addr_inc_en,
    input  logic        i_debug_ld_data_en,
    input  logic [1:0]  i_debug_datax,
    input  logic [15:0] i_debug_din_din,
    input  logic [15:0] i_debug_regb_data,
    input  logic [15:0] i_debug_cc_data,
    input  logic [15:0] i_debug_pc_a_next,
    output logic        o_debug_stop,
    output logic        o_debug_mode,
    output logic        o_debug_req,
    input  logic        i_debug_ack
);

    logic [7:0] r_op;
    logic [2:0] r_mode;
    dbg_word_t  r_addr;
    dbg_word_t  r_data;
    logic       r_req;
    logic       w_wr_rise;
    logic       w_rd_rise;
    logic       w_wr_op;
    logic       w_req_set;
    logic       w_req_clr;
    dbg_word_t  w_ld_src;
    logic [7:0] w_dout;

    debug_strobe_sync u_wr_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_strobe_n (i_debug_wrn),
        .o_rise     (w_wr_rise)
    );

    debug_strobe_sync u_rd_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_strobe_n (i_debug_rdn),
        .o_rise     (w_rd_rise)
    );

    assign w_wr_op = w_wr_rise && i_debug_addr == DEBUG_ADDRX_OP;
    // Finishing a DH read re-issues the current command so the host can stream data.
    assign w_req_set = (w_wr_op && i_debug_din[3:0] != DEBUG_OPX_NONE)
                    || (w_rd_rise && i_debug_addr == DEBUG_ADDRX_DH && r_op[3:0] != DEBUG_OPX_NONE);
    assign w_req_clr = (w_wr_op && i_debug_din[3:0] == DEBUG_OPX_NONE) || i_debug_ack;
    assign w_ld_src  = i_debug_datax == DEBUG_DATAX_DIN_DIN   ? i_debug_din_din
                     : i_debug_datax == DEBUG_DATAX_REGB_DATA ? i_debug_regb_data
                     : i_debug_datax == DEBUG_DATAX_CC_DATA   ? i_debug_cc_data
                     : i_debug_pc_a_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op   <= 8'h00;
            r_mode <= 3'b000;
            r_addr <= 16'h0000;
            r_data <= 16'h0000;
            r_req  <= 1'b0;
        end else begin
            r_op   <= w_wr_op ? i_debug_din : r_op;
            r_mode <= (w_wr_rise && i_debug_addr == DEBUG_ADDRX_MODE) ? i_debug_din[2:0] : r_mode;
            r_addr <= (w_wr_rise && i_debug_addr == DEBUG_ADDRX_AL) ? {r_addr[15:8], i_debug_din}
                    : (w_wr_rise && i_debug_addr == DEBUG_ADDRX_AH) ? {i_debug_din, r_addr[7:0]}
                    : i_debug_addr_inc_en ? r_addr + 16'd2 : r_addr;
            r_data <= (w_wr_rise && i_debug_addr == DEBUG_ADDRX_DL) ? {r_data[15:8], i_debug_din}
                    : (w_wr_rise && i_debug_addr == DEBUG_ADDRX_DH) ? {i_debug_din, r_data[7:0]}
                    : i_debug_ld_data_en ? w_ld_src : r_data;
            r_req  <= w_req_set ? 1'b1 : w_req_clr ? 1'b0 : r_req;
        end
    end

    always_comb begin
        w_dout = 8'h00;
        if (!i_debug_rdn) begin
            case (i_debug_addr)
                DEBUG_ADDRX_OP:     w_dout = r_op;
                DEBUG_ADDRX_MODE:   w_dout = {5'b0, r_mode};
                DEBUG_ADDRX_AL:     w_dout = r_addr[7:0];
                DEBUG_ADDRX_AH:     w_dout = r_addr[15:8];
                DEBUG_ADDRX_DL:     w_dout = r_data[7:0];
                DEBUG_ADDRX_DH:     w_dout = r_data[15:8];
                DEBUG_ADDRX_STATUS: w_dout = debug_status(r_mode[1], r_mode[0], r_req);
                default:            w_dout = 8'h00;
            endcase
        end
    end

    assign o_debug_dout     = w_dout;
    assign o_reset          = ~i_rst_n | r_mode[2];
    assign o_debug_op       = r_op[3:0];
    assign o_debug_argx_out = r_op[7:4];
    assign o_debug_addr_out = r_addr;
    assign o_debug_data_out = r_data;
    assign o_debug_mode     = r_mode[0];
    assign o_debug_stop     = r_mode[1];
    assign o_debug_req      = r_req;

endmodule

// File: tb/tb_debug_port.sv
// tb_debug_port: directed self-checking bench for debug_port host writes, reads, handshake and priorities.
module tb_debug_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reset;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic [2:0]  addr = 3'd0;
    logic        rdn = 1'b1;
    logic        wrn = 1'b1;
    logic [3:0]  op;
    logic [3:0]  argx;
    logic [15:0] addr_out;
    logic [15:0] data_out;
    logic        inc = 1'b0;
    logic        ld = 1'b0;
    logic [1:0]  datax = 2'd0;
    logic [15:0] src_din = 16'haabb;
    logic [15:0] src_regb = 16'hbbcc;
    logic [15:0] src_cc = 16'hccdd;
    logic [15:0] src_pc = 16'hddee;
    logic        stop;
    logic        mode;
    logic        req;
    logic        ack = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    debug_port dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .o_reset             (reset),
        .i_debug_din         (din),
        .o_debug_dout        (dout),
        .i_debug_addr        (addr),
        .i_debug_rdn         (rdn),
        .i_debug_wrn         (wrn),
        .o_debug_op          (op),
        .o_debug_argx_out    (argx),
        .o_debug_addr_out    (addr_out),
        .o_debug_data_out    (data_out),
        .i_debug_addr_inc_en (inc),
        .i_debug_ld_data_en  (ld),
        .i_debug_datax       (datax),
        .i_debug_din_din     (src_din),
        .i_debug_regb_data   (src_regb),
        .i_debug_cc_data     (src_cc),
        .i_debug_pc_a_next   (src_pc),
        .o_debug_stop        (stop),
        .o_debug_mode        (mode),
        .o_debug_req         (req),
        .i_debug_ack         (ack)
    );

    // Side inputs are held high exactly across the edge on which the write lands.
    task automatic host_write_x(input logic [2:0] a, input logic [7:0] d, input logic s_inc, input logic s_ld, input logic s_ack);
        @(negedge clk);
        addr = a;
        din = d;
        wrn = 1'b0;
        repeat (3) @(negedge clk);
        wrn = 1'b1;
        repeat (2) @(negedge clk);
        inc = s_inc;
        ld = s_ld;
        ack = s_ack;
        @(negedge clk);
        inc = 1'b0;
        ld = 1'b0;
        ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        host_write_x(a, d, 1'b0, 1'b0, 1'b0);
    endtask

    // Leaves RDN just raised on a falling edge so callers can time the re-trigger.
    task automatic host_read(input logic [2:0] a, output logic [7:0] v);
        @(negedge clk);
        addr = a;
        rdn = 1'b0;
        @(negedge clk);
        #1 v = dout;
        repeat (2) @(negedge clk);
        rdn = 1'b1;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (reset !== 1'b1) begin bad++; $display("FAIL reset_out_in_reset got=%0b exp=1", reset); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({dout, addr_out, data_out, op, argx, req, stop, mode, reset} !== 46'h0) begin
            bad++;
            $display("FAIL reset_state dout=%h addr=%h data=%h op=%h argx=%h req=%b stop=%b mode=%b reset=%b exp all 0",
                     dout, addr_out, data_out, op, argx, req, stop, mode, reset);
        end
    endtask

    task automatic test_mode();
        logic [7:0] v;
        host_write(3'd1, 8'h03);
        host_write(3'd0, 8'h00);
        total++;
        if ({stop, mode, req} !== 3'b110) begin bad++; $display("FAIL mode_stop got stop/mode/req=%b exp=110", {stop, mode, req}); end
        host_read(3'd6, v);
        settle();
        total++;
        if (v !== 8'h06) begin bad++; $display("FAIL status_read got=%h exp=06", v); end
        host_write(3'd1, 8'h07);
        total++;
        if (reset !== 1'b1) begin bad++; $display("FAIL mode_reset_bit got=%b exp=1", reset); end
        host_write(3'd1, 8'h03);
        total++;
        if (reset !== 1'b0) begin bad++; $display("FAIL mode_reset_clear got=%b exp=0", reset); end
    endtask

    task automatic test_wr_mem();
        logic [7:0] v;
        host_write(3'd3, 8'h56);
        host_write(3'd2, 8'h78);
        host_write(3'd5, 8'h12);
        host_write(3'd4, 8'h34);
        host_write(3'd0, 8'h02);
        total++;
        if ({addr_out, data_out, op, req} !== {16'h5678, 16'h1234, 4'h2, 1'b1}) begin
            bad++;
            $display("FAIL wr_mem addr=%h data=%h op=%h req=%b exp 5678 1234 2 1", addr_out, data_out, op, req);
        end
        pulse_ack();
        total++;
        if (req !== 1'b0) begin bad++; $display("FAIL ack_clear got=%b exp=0", req); end
        host_read(3'd0, v);
        settle();
        total++;
        if (v !== 8'h02) begin bad++; $display("FAIL op_read got=%h exp=02", v); end
        host_read(3'd3, v);
        settle();
        total++;
        if (v !== 8'h56) begin bad++; $display("FAIL ah_read got=%h exp=56", v); end
    endtask

    task automatic test_inc();
        @(negedge clk);
        inc = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        total++;
        if ({addr_out, data_out} !== {16'h567a, 16'h1234}) begin
            bad++;
            $display("FAIL inc addr=%h data=%h exp 567a 1234", addr_out, data_out);
        end
        host_write(3'd3, 8'hff);
        host_write(3'd2, 8'hfe);
        @(negedge clk);
        inc = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        total++;
        if (addr_out !== 16'h0000) begin bad++; $display("FAIL inc_wrap got=%h exp=0000", addr_out); end
    endtask

    task automatic test_datax();
        logic [15:0] exp;
        logic [7:0]  v;
        for (int i = 0; i < 4; i++) begin
            exp = i == 0 ? 16'haabb : i == 1 ? 16'hbbcc : i == 2 ? 16'hccdd : 16'hddee;
            host_write(3'd0, 8'h53);
            total++;
            if ({op, argx, req} !== {4'h3, 4'h5, 1'b1}) begin
                bad++;
                $display("FAIL rd_reg_issue sel=%0d op=%h argx=%h req=%b exp 3 5 1", i, op, argx, req);
            end
            @(negedge clk);
            datax = i[1:0];
            ack = 1'b1;
            ld = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            ld = 1'b0;
            total++;
            if ({data_out, req} !== {exp, 1'b0}) begin
                bad++;
                $display("FAIL ld_data sel=%0d data=%h req=%b exp %h 0", i, data_out, req, exp);
            end
            host_read(3'd4, v);
            settle();
            total++;
            if (v !== exp[7:0]) begin bad++; $display("FAIL dl_read sel=%0d got=%h exp=%h", i, v, exp[7:0]); end
            host_read(3'd5, v);
            total++;
            if (v !== exp[15:8]) begin bad++; $display("FAIL dh_read sel=%0d got=%h exp=%h", i, v, exp[15:8]); end
            @(negedge clk);
            total++;
            if (req !== 1'b0) begin bad++; $display("FAIL dh_retrig_early sel=%0d got=%b exp=0", i, req); end
            repeat (2) @(negedge clk);
            total++;
            if (req !== 1'b1) begin bad++; $display("FAIL dh_retrig sel=%0d got=%b exp=1", i, req); end
            settle();
        end
    endtask

    task automatic test_priority();
        logic [7:0] v;
        host_write(3'd3, 8'h10);
        host_write(3'd2, 8'h00);
        host_write_x(3'd2, 8'h20, 1'b1, 1'b0, 1'b0);
        total++;
        if (addr_out !== 16'h1020) begin bad++; $display("FAIL al_beats_inc got=%h exp=1020", addr_out); end
        datax = 2'd0;
        host_write_x(3'd4, 8'h99, 1'b0, 1'b1, 1'b0);
        total++;
        if (data_out !== 16'hdd99) begin bad++; $display("FAIL dl_beats_ld got=%h exp=dd99", data_out); end
        pulse_ack();
        host_write_x(3'd0, 8'h01, 1'b0, 1'b0, 1'b1);
        total++;
        if (req !== 1'b1) begin bad++; $display("FAIL set_beats_ack got=%b exp=1", req); end
        host_write(3'd0, 8'h00);
        total++;
        if (req !== 1'b0) begin bad++; $display("FAIL op_none_clears got=%b exp=0", req); end
        host_read(3'd5, v);
        repeat (3) @(negedge clk);
        total++;
        if (req !== 1'b0) begin bad++; $display("FAIL dh_no_retrig_none got=%b exp=0", req); end
        host_write(3'd7, 8'hff);
        host_read(3'd7, v);
        settle();
        total++;
        if (v !== 8'h00) begin bad++; $display("FAIL rsvd_read got=%h exp=00", v); end
    endtask

    task automatic test_dout_idle();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            addr = i[2:0];
            #1;
            total++;
            if (dout !== 8'h00) begin bad++; $display("FAIL dout_idle addr=%0d got=%h exp=00", i, dout); end
        end
    endtask

    task automatic test_reset_mid();
        host_write(3'd0, 8'h72);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({addr_out, data_out, op, argx, req, stop, mode, reset} !== 39'h1) begin
            bad++;
            $display("FAIL reset_mid addr=%h data=%h op=%h argx=%h req=%b stop=%b mode=%b reset=%b exp 0..0 reset=1",
                     addr_out, data_out, op, argx, req, stop, mode, reset);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({reset, req} !== 2'b00) begin bad++; $display("FAIL reset_release reset/req=%b exp=00", {reset, req}); end
    endtask

    initial begin
        test_reset();
        test_mode();
        test_wr_mem();
        test_inc();
        test_datax();
        test_priority();
        test_dout_idle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_port.md
# debug_port

Host-side debug access port for the CPU core. An external 8-bit asynchronous bus (RDN/WRN strobes, 3-bit register address) programs mode, address, data and opcode registers. The port presents a 16-bit address/data and a command to the core through a REQ/ACK handshake. It sits between the external debug header and the core's control unit, and lets a host stop the CPU, read/write memory and read internal registers.

## Interface
- No parameters.
- CLK  in  1  core clock, rising edge.
- RESETN  in  1  asynchronous active-low reset.
- RESET  out  1  active-high reset to the core: ~RESETN OR MODE.reset bit.
- DEBUG_DIN  in  8  host write data.
- DEBUG_DOUT  out  8  host read data.
- DEBUG_ADDR  in  3  host register select.
- DEBUG_RDN / DEBUG_WRN  in  1  host read/write strobes, active-low, asynchronous to CLK.
- DEBUG_OP  out  4  current debug opcode.
- DEBUG_ARGX_OUT  out  4  opcode argument (register index).
- DEBUG_ADDR_OUT  out  16  debug address register.
- DEBUG_DATA_OUT  out  16  debug data register.
- DEBUG_ADDR_INC_EN  in  1  core request to increment the address by 2.
- DEBUG_LD_DATA_EN  in  1  core request to load the data register from the selected source.
- DEBUG_DATAX  in  2  load source select: 0 DIN_DIN, 1 REGB_DATA, 2 CC_DATA, 3 PC_A_NEXT.
- DEBUG_DIN_DIN, DEBUG_REGB_DATA, DEBUG_CC_DATA, DEBUG_PC_A_NEXT  in  16  load sources.
- DEBUG_STOP  out  1  halt request to the core.
- DEBUG_MODE  out  1  debug mode active.
- DEBUG_REQ  out  1  command pending to the core.
- DEBUG_ACK  in  1  core accepted the command.

## Operation
- Register map (DEBUG_ADDRX_*): 0 OP, 1 MODE, 2 AL, 3 AH, 4 DL, 5 DH, 6 STATUS (read-only), 7 reserved (reads 0, writes ignored).
- The OP byte holds the opcode in [3:0] (DEBUG_OP) and ARGX in [7:4] (DEBUG_ARGX_OUT).
- Opcodes (DEBUG_OPX_*): NONE=0, RD_MEM=1, WR_MEM=2, RD_REG=3, WR_REG=4, STEP=5. Other values are passed through to the core unchanged.
- MODE byte:
  - bit0 → DEBUG_MODE.
  - bit1 → DEBUG_STOP.
  - bit2 → reset request.
  - DEBUG_MODEX_STOP = 8'h03.
- STATUS read: {5'b0, STOP, MODE, REQ}.
- Host write: a register is updated with DEBUG_DIN when the synchronized WRN rises (end of strobe), addressed by DEBUG_ADDR. AL/AH and DL/DH write individual bytes of ADDR_OUT/DATA_OUT.
- Writing OP sets REQ if opcode ≠ NONE, and clears REQ if opcode = NONE.
- Core handshake:
  - DEBUG_ACK high on a clock edge clears REQ.
  - DEBUG_LD_DATA_EN loads DATA_OUT from the DATAX-selected source.
  - DEBUG_ADDR_INC_EN adds 2 to ADDR_OUT, wrapping modulo 2^16.
- Host read: while DEBUG_RDN is low, DOUT = the addressed register; otherwise DOUT = 8'h00. Read is combinational and uses the raw RDN.
- Streaming: when the synchronized RDN rises with DEBUG_ADDR = DH and OP ≠ NONE, REQ is set again, re-issuing the current command.
- Priorities:
  - Set REQ beats ACK in the same cycle.
  - A host write to AL/AH beats INC.
  - A host write to DL/DH beats LD_DATA_EN.

## Timing
- Asynchronous reset clears every register: DOUT, OP, ARGX, ADDR_OUT, DATA_OUT, MODE all 0; REQ, STOP, MODE 0; RESET high while RESETN is low.
- RDN/WRN pass through 2-flop synchronizers plus an edge-detect flop.
- A register write takes effect on the 3rd CLK rising edge after WRN rises.
- The DH-read re-trigger asserts REQ on the 3rd rising edge after RDN rises:
  - REQ must still be low 1 edge after the rise.
  - REQ must be high after 3 edges.
- ACK, INC and LD act on the same edge they are sampled high; outputs update one cycle later.
- Hosts hold strobes low ≥ 3 CLK periods and high ≥ 3 CLK periods.

## Structure
- Shared constants file (already used by the core) holds DEBUG_ADDRX_*, DEBUG_OPX_*, DEBUG_MODEX_* and DEBUG_DATAX_*.
- One natural sub-module: debug_strobe_sync, a 2-flop synchronizer with rising-edge pulse, instantiated for RDN and WRN.

## Test plan
- Reset: pulse RESETN low → DOUT=00, ADDR_OUT=0000, DATA_OUT=0000, OP=NONE, ARGX=0, REQ=0.
- Write MODE=03, OP=NONE → STOP=1, MODE=1, REQ=0.
- Write AH=56, AL=78, DH=12, DL=34, then OP=WR_MEM → ADDR_OUT=5678, DATA_OUT=1234, REQ=1. Pulse ACK → REQ=0.
- Pulse ADDR_INC_EN for one cycle → ADDR_OUT=567a, DATA_OUT unchanged. Also check that FFFE increments to 0000.
- For each DATAX (DIN=aabb, REGB=bbcc, CC=ccdd, PC=ddee):
  - Write OP=RD_REG, then pulse ACK+LD_DATA_EN.
  - Read DL → low byte; read DH → high byte.
  - REQ=0 one cycle after RDN rises, REQ=1 three cycles after.
- While RDN is high, DOUT=00 for any address. Pulse RESETN mid-command → REQ and all registers return to 0.
